// File: rtl/fusion_seq_pkg.sv
// Shared types and constants for the fusion unit operand sequencer.
// The optional FUSION_SEQ_SAT_EN macro is consumed by fusion_seq_acc.
package fusion_seq_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    localparam logic [2:0] W4        = 3'b100;
    localparam logic [2:0] W2        = 3'b010;
    localparam int         LEN_W_DEF = 8;
    localparam int         ACC_W_DEF = 20;
endpackage

// File: rtl/fusion_seq_acc.sv
// Accumulator for fusion unit partial sums: extend, add, register.
// FUSION_SEQ_SAT_EN selects clamping with a sticky overflow flag; otherwise it wraps.
module fusion_seq_acc
    import fusion_seq_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_signed,
    input  logic [7:0]       i_psum,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_ovf
);
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_ext;

    assign w_ext = i_signed ? {{(ACC_W-8){i_psum[7]}}, i_psum}
                            : {{(ACC_W-8){1'b0}}, i_psum};
    assign o_acc = r_acc;

`ifdef FUSION_SEQ_SAT_EN
    logic             r_ovf;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_next;
    logic             w_clamp;

    // One guard bit: signed overflow shows as guard != MSB, unsigned as a carry.
    always_comb begin
        w_sum   = '0;
        w_next  = '0;
        w_clamp = 1'b0;
        if (i_signed) begin
            w_sum   = {r_acc[ACC_W-1], r_acc} + {w_ext[ACC_W-1], w_ext};
            w_clamp = w_sum[ACC_W] ^ w_sum[ACC_W-1];
            w_next  = w_clamp ? {w_sum[ACC_W], {(ACC_W-1){~w_sum[ACC_W]}}}
                              : w_sum[ACC_W-1:0];
        end else begin
            w_sum   = {1'b0, r_acc} + {1'b0, w_ext};
            w_clamp = w_sum[ACC_W];
            w_next  = w_clamp ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_en) begin
            r_acc <= w_next;
            r_ovf <= r_ovf | w_clamp;
        end
    end

    assign o_ovf = r_ovf;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + w_ext;
    end

    assign o_ovf = 1'b0;
`endif
endmodule

// File: rtl/fusion_seq_ctrl.sv
// Sequencer feeding one fusion_unit an operand stream and summing its psums.
// Build with FUSION_SEQ_SAT_EN for a saturating accumulator and sticky res_ovf.
module fusion_seq_ctrl
    import fusion_seq_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [2:0]       cfg_in_width,
    input  logic [2:0]       cfg_weight_width,
    input  logic             cfg_s_in,
    input  logic             cfg_s_weight,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_in,
    input  logic [3:0]       op_weight,
    output logic [3:0]       fu_in,
    output logic [3:0]       fu_weight,
    output logic [2:0]       fu_in_width,
    output logic [2:0]       fu_weight_width,
    output logic             fu_s_in,
    output logic             fu_s_weight,
    input  logic [7:0]       fu_psum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_acc,
    output logic             res_ovf
);
    state_t           r_state;
    logic [LEN_W-1:0] r_count;
    logic             r_stage_valid;
    logic             r_cfg_ready, r_op_ready, r_res_valid;
    logic [3:0]       r_fu_in, r_fu_weight;
    logic [2:0]       r_fu_in_width, r_fu_weight_width;
    logic             r_fu_s_in, r_fu_s_weight;
    logic             w_cfg_hs, w_op_hs;

    assign w_cfg_hs = cfg_valid & r_cfg_ready;
    assign w_op_hs  = op_valid & r_op_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_count           <= '0;
            r_stage_valid     <= 1'b0;
            r_cfg_ready       <= 1'b1;
            r_op_ready        <= 1'b0;
            r_res_valid       <= 1'b0;
            r_fu_in           <= '0;
            r_fu_weight       <= '0;
            r_fu_in_width     <= W4;
            r_fu_weight_width <= W4;
            r_fu_s_in         <= 1'b0;
            r_fu_s_weight     <= 1'b0;
        end else begin
            r_stage_valid <= 1'b0;
            unique case (r_state)
                IDLE: if (w_cfg_hs) begin
                    r_fu_in_width     <= cfg_in_width;
                    r_fu_weight_width <= cfg_weight_width;
                    r_fu_s_in         <= cfg_s_in;
                    r_fu_s_weight     <= cfg_s_weight;
                    r_count           <= cfg_len;
                    r_cfg_ready       <= 1'b0;
                    if (cfg_len == '0) begin
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_state    <= LOAD;
                        r_op_ready <= 1'b1;
                    end
                end
                LOAD: if (w_op_hs) begin
                    r_fu_in       <= op_in;
                    r_fu_weight   <= op_weight;
                    r_stage_valid <= 1'b1;
                    r_count       <= r_count - LEN_W'(1);
                    if (r_count == LEN_W'(1)) begin
                        r_state    <= DRAIN;
                        r_op_ready <= 1'b0;
                    end
                end
                // Last psum lands in the accumulator on this edge.
                DRAIN: begin
                    r_state     <= DONE;
                    r_res_valid <= 1'b1;
                end
                DONE: if (res_ready) begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fusion_seq_acc #(.ACC_W(ACC_W)) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_cfg_hs),
        .i_en     (r_stage_valid),
        .i_signed (r_fu_s_in | r_fu_s_weight),
        .i_psum   (fu_psum),
        .o_acc    (res_acc),
        .o_ovf    (res_ovf)
    );

    assign cfg_ready       = r_cfg_ready;
    assign op_ready        = r_op_ready;
    assign res_valid       = r_res_valid;
    assign fu_in           = r_fu_in;
    assign fu_weight       = r_fu_weight;
    assign fu_in_width     = r_fu_in_width;
    assign fu_weight_width = r_fu_weight_width;
    assign fu_s_in         = r_fu_s_in;
    assign fu_s_weight     = r_fu_s_weight;
endmodule

// File: tb/tb_fusion_seq_ctrl.sv
// Bench for fusion_seq_ctrl: directed and random jobs against a sum-of-products model.
module tb_fusion_seq_ctrl;
    import fusion_seq_pkg::*;

    localparam int LEN_W = 8;
    localparam int ACC_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_valid = 1'b0, cfg_ready;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [2:0]       cfg_in_width = W4, cfg_weight_width = W4;
    logic             cfg_s_in = 1'b0, cfg_s_weight = 1'b0;
    logic             op_valid = 1'b0, op_ready;
    logic [3:0]       op_in = '0, op_weight = '0;
    logic [3:0]       fu_in, fu_weight;
    logic [2:0]       fu_in_width, fu_weight_width;
    logic             fu_s_in, fu_s_weight;
    logic [7:0]       fu_psum;
    logic             res_valid, res_ready = 1'b0;
    logic [ACC_W-1:0] res_acc;
    logic             res_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] pin [256];
    logic [3:0] pw  [256];

    always #5 clk = ~clk;

    fusion_seq_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
        .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
        .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight),
        .op_valid(op_valid), .op_ready(op_ready), .op_in(op_in), .op_weight(op_weight),
        .fu_in(fu_in), .fu_weight(fu_weight),
        .fu_in_width(fu_in_width), .fu_weight_width(fu_weight_width),
        .fu_s_in(fu_s_in), .fu_s_weight(fu_s_weight), .fu_psum(fu_psum),
        .res_valid(res_valid), .res_ready(res_ready), .res_acc(res_acc), .res_ovf(res_ovf)
    );

    function automatic int opv(input logic [3:0] v, input logic s);
        return s ? int'($signed(v)) : int'(v);
    endfunction

    // Behavioural 4x4 fusion unit: plain integer product, truncated to 8 bits.
    always_comb fu_psum = 8'(opv(fu_in, fu_s_in) * opv(fu_weight, fu_s_weight));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input int len, input logic [2:0] iw, input logic [2:0] ww,
                           input bit si, input bit sw, input logic [15:0] vpat,
                           input int bub, input int stall, input string tag);
        int acc = 0;
        bit ovf = 0;
        int p, hs = 0, cyc = 0;
        bit rdy;
        logic [ACC_W-1:0] exp_acc;
        for (int i = 0; i < len; i++) begin
            p = opv(pin[i], si) * opv(pw[i], sw);
`ifdef FUSION_SEQ_SAT_EN
            acc += p;
            if (si | sw) begin
                if (acc > (1 << (ACC_W-1)) - 1) begin acc = (1 << (ACC_W-1)) - 1; ovf = 1; end
                if (acc < -(1 << (ACC_W-1)))    begin acc = -(1 << (ACC_W-1));    ovf = 1; end
            end else if (acc > (1 << ACC_W) - 1) begin
                acc = (1 << ACC_W) - 1; ovf = 1;
            end
`else
            acc = (acc + p) & ((1 << ACC_W) - 1);
`endif
        end
        exp_acc = ACC_W'(acc);

        chk({tag, ".cfg_ready_idle"}, cfg_ready, 1);
        cfg_valid = 1; cfg_len = LEN_W'(len); cfg_in_width = iw; cfg_weight_width = ww;
        cfg_s_in = si; cfg_s_weight = sw;
        @(negedge clk);
        cfg_valid = 0; cfg_len = LEN_W'($urandom); cfg_s_in = ~si; cfg_in_width = ~iw;
        chk({tag, ".fu_widths"}, {fu_in_width, fu_weight_width}, {iw, ww});
        chk({tag, ".fu_signs"}, {fu_s_in, fu_s_weight}, {si, sw});
        chk({tag, ".cfg_ready_busy"}, cfg_ready, 0);
        if (len == 0) begin
            chk({tag, ".op_ready_len0"}, op_ready, 0);
        end else begin
            while (hs < len && cyc < 2000) begin
                rdy = op_ready;
                op_valid = (vpat != 0) ? vpat[cyc % 16] : ($urandom_range(99) >= bub);
                op_in = pin[hs]; op_weight = pw[hs];
                @(negedge clk);
                if (op_valid && rdy) hs++;
                cyc++;
            end
            op_valid = 0;
            chk({tag, ".handshakes"}, hs, len);
            chk({tag, ".drain_res_valid"}, res_valid, 0);
            chk({tag, ".drain_op_ready"}, op_ready, 0);
            @(negedge clk);
        end
        chk({tag, ".res_valid"}, res_valid, 1);
        chk({tag, ".res_acc"}, res_acc, exp_acc);
        chk({tag, ".res_ovf"}, res_ovf, ovf);
        for (int k = 0; k < stall; k++) begin
            cfg_valid = 1; op_valid = 1;
            @(negedge clk);
            chk({tag, ".stall_valid"}, res_valid, 1);
            chk({tag, ".stall_acc"}, res_acc, exp_acc);
            chk({tag, ".stall_cfg_ready"}, cfg_ready, 0);
        end
        cfg_valid = 0; op_valid = 0; res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk({tag, ".post_res_valid"}, res_valid, 0);
        chk({tag, ".post_cfg_ready"}, cfg_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.cfg_ready", cfg_ready, 1);
        chk("rst.op_ready", op_ready, 0);
        chk("rst.res_valid", res_valid, 0);
        chk("rst.res_acc", res_acc, 0);
        chk("rst.res_ovf", res_ovf, 0);
        chk("rst.fu_ops", {fu_in, fu_weight}, 0);
        chk("rst.fu_widths", {fu_in_width, fu_weight_width}, {W4, W4});
        chk("rst.fu_signs", {fu_s_in, fu_s_weight}, 0);
        rst_n = 1;
        @(negedge clk);

        pin[0] = 15; pw[0] = 15; pin[1] = 1; pw[1] = 2; pin[2] = 3; pw[2] = 4;
        run_job(3, W4, W4, 0, 0, 16'hFFFF, 0, 0, "u3");
        pin[0] = 4'b1000; pw[0] = 4'b1000; pin[1] = 4'b1101; pw[1] = 5;
        run_job(2, W4, W4, 1, 1, 16'hFFFF, 0, 1, "s2");
        run_job(0, W4, W2, 0, 1, 16'hFFFF, 0, 2, "len0");
        pin[0] = 2; pw[0] = 9; pin[1] = 7; pw[1] = 3;
        run_job(2, W2, W4, 0, 0, 16'hFFF9, 0, 5, "bubble");
        for (int i = 0; i < 8; i++) begin pin[i] = 4'b1000; pw[i] = 4'b1000; end
        run_job(8, W4, W4, 1, 1, 16'hFFFF, 0, 0, "sat");

        // Abort a job with reset after two of four pairs.
        cfg_valid = 1; cfg_len = 4; cfg_in_width = W2; cfg_s_in = 1; cfg_s_weight = 0;
        @(negedge clk);
        cfg_valid = 0; op_valid = 1; op_in = 5; op_weight = 6;
        repeat (2) @(negedge clk);
        op_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("abort.op_ready", op_ready, 0);
        chk("abort.cfg_ready", cfg_ready, 1);
        chk("abort.res_valid", res_valid, 0);
        chk("abort.res_acc", res_acc, 0);
        chk("abort.fu_ops", {fu_in, fu_weight}, 0);
        chk("abort.fu_widths", {fu_in_width, fu_weight_width}, {W4, W4});
        chk("abort.fu_signs", {fu_s_in, fu_s_weight}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        pin[0] = 2; pw[0] = 3;
        run_job(1, W4, W4, 0, 0, 16'hFFFF, 0, 0, "after_rst");

        for (int j = 0; j < 12; j++) begin
            int len;
            len = $urandom_range(24, 1);
            for (int i = 0; i < len; i++) begin
                pin[i] = 4'($urandom); pw[i] = 4'($urandom);
            end
            run_job(len, 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                    16'h0000, 30, $urandom_range(3, 0), $sformatf("rnd%0d", j));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fusion_seq_ctrl.md
Name: fusion_seq_ctrl

Overview:
Sequencer that feeds one fusion_unit a stream of 4-bit input/weight operand pairs for a dot-product job of programmable length. It latches the job configuration and holds it stable on the fusion unit. It registers each operand pair into the unit and accumulates the combinational psum_fwd into a wide accumulator. It returns the final sum over a valid/ready result port. It sits between the operand buffers and the output/psum collection logic.

Parameters:
LEN_W, 8, width of job length (max pairs = 2^LEN_W-1)
ACC_W, 20, accumulator/result width (>= 9)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  job request
cfg_ready  out  1  controller idle, can accept job
cfg_len  in  LEN_W  number of operand pairs
cfg_in_width  in  3  in_width code passed to fusion unit
cfg_weight_width  in  3  weight_width code passed to fusion unit
cfg_s_in  in  1  input signed
cfg_s_weight  in  1  weight signed
op_valid  in  1  operand pair valid
op_ready  out  1  operand pair accepted
op_in  in  4  input operand
op_weight  in  4  weight operand
fu_in  out  4  registered operand to fusion unit
fu_weight  out  4  registered weight to fusion unit
fu_in_width  out  3  latched config
fu_weight_width  out  3  latched config
fu_s_in  out  1  latched config
fu_s_weight  out  1  latched config
fu_psum  in  8  fusion unit psum_fwd (combinational from fu_*)
res_valid  out  1  result valid
res_ready  in  1  result consumed
res_acc  out  ACC_W  accumulated sum
res_ovf  out  1  sticky overflow (see Optional Feature)

Behaviour:
- Reset: state IDLE; fu_in, fu_weight, fu_s_in, fu_s_weight, res_acc, res_ovf, res_valid, op_ready = 0; cfg_ready = 1; fu_in_width and fu_weight_width = 3'b100; count = 0; stage_valid = 0; acc = 0. Reset mid-job aborts with no result.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg handshake: latch width/sign config onto fu_*, clear acc and res_ovf, count<=cfg_len.
  - Go to LOAD, or to DONE if cfg_len==0.
- LOAD:
  - op_ready=1.
  - On op handshake: fu_in<=op_in, fu_weight<=op_weight, stage_valid<=1, count<=count-1.
  - If count==1 at the handshake, go to DRAIN.
  - With no handshake: stage_valid<=0 and fu_in/fu_weight hold their values.
- Accumulate, every state: if stage_valid, acc <= acc + ext(fu_psum).
  - ext is sign-extension when (fu_s_in|fu_s_weight), otherwise zero-extension.
  - Arithmetic is ACC_W-bit and wraps modulo 2^ACC_W.
- DRAIN: stage_valid<=0; the final psum is accumulated this cycle; go to DONE.
- DONE:
  - res_valid=1 and res_acc=acc, both held stable until res_ready.
  - On res_ready, go to IDLE with cfg_ready=1 the next cycle.
- Latency: res_valid rises 2 cycles after the last op handshake, or 1 cycle after the cfg handshake when len==0.
- Throughput: 1 pair/cycle.
- fu_* config stays constant from job start until the next cfg handshake.
- cfg_valid outside IDLE and op_valid outside LOAD are ignored; the corresponding ready is 0.
- Width codes are passed through unvalidated.

Optional Feature:
FUSION_SEQ_SAT_EN
- Defined: the accumulate saturates to the ACC_W signed range when signed, or the unsigned range when unsigned. res_ovf sets sticky on any clamp and clears on the next cfg handshake.
- Undefined: the accumulate wraps and res_ovf is tied 0.

Decomposition:
- Shared package: state enum (IDLE/LOAD/DRAIN/DONE), width code constants W4=3'b100 and W2=3'b010, default LEN_W/ACC_W.
- One natural sub-module: fusion_seq_acc, the extend + add (+ saturate) accumulator register.
- fusion_unit is instantiated by the parent, not inside this block.

Test Plan:
- Unsigned W4, len=3, pairs (15,15),(1,2),(3,4), bench driving fu_psum from a reference model -> res_acc=239, res_valid 2 cycles after the 3rd handshake, res_ovf=0.
- Signed in+weight, len=2, pairs (4'b1000,4'b1000),(4'b1101,4'd5) -> psums 64 and -15 (8'hF1 sign-extended) -> res_acc=49.
- cfg_len=0 -> DONE the next cycle, res_acc=0, no op_ready asserted.
- op_valid bubbles (toggle 1,0,0,1) with len=2 and res_ready low 5 cycles -> correct sum, res_acc/res_valid stable while stalled, cfg_ready=0 until the result handshake.
- FUSION_SEQ_SAT_EN, ACC_W=10, signed, len=8 of (-8,-8) -> res_acc=511, res_ovf=1. Without the macro -> res_acc=-512 (10'h200), res_ovf=0.
- rst_n asserted during LOAD after 2 of 4 pairs -> all outputs at reset values immediately. A new job len=1 (2,3) then gives res_acc=6.
